float_argmin_reduce: RTL and testbench

Streaming argmin reducer that consumes the result of the single-precision `float_lessthan` comparator. It accepts a vector of IEEE-754 floats one element at a time and drives each candidate together with the current minimum into the comparator. On every `cmp_q` it updates the running minimum and its index, then returns the minimum value and its position when the vector ends. It sits between a float data stream and the selection/sorting logic of the compute pipelines.

---
 rtl/float_argmin_reduce.sv | 184 ++++++++++++++++++
 tb/tb_float_argmin_reduce.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_argmin_reduce.sv
// -----------------------------------------------------------------------------
// float_argmin_reduce
//
// Streaming argmin over a vector of IEEE-754 single-precision floats. Elements
// arrive one at a time. The first element seeds the running minimum. Every
// later element is sent, with the current minimum, to an external less-than
// comparator. When the result comes back, the block updates the minimum and
// its zero-based index. After the last element, the block presents the
// minimum value and its position.
//
// Handshake rule (both streams): a transfer happens on a rising edge where
// valid && ready. Once valid is raised, the producer holds its data stable
// until that edge. in_ready and out_valid are decoded from the state register
// only, so neither has a combinational path from any input.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-low (0 = reset)
//   in_value     element value (IEEE-754 single)
//   in_valid     element present
//   in_last      element is the last of its vector
//   in_ready     block can accept an element
//   cmp_a        candidate, to comparator in1
//   cmp_b        current minimum, to comparator in2
//   cmp_valid    one-cycle compare request
//   cmp_q        comparator result (cmp_a < cmp_b)
//   cmp_q_valid  comparator result valid (latency 0 or more cycles)
//   out_value    minimum of the completed vector
//   out_index    zero-based position of the minimum
//   out_valid    result present
//   out_ready    consumer takes the result
//   dbg_state    current FSM state, for observation only
// -----------------------------------------------------------------------------
module float_argmin_reduce #(
  parameter int INDEX_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            in_value,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [31:0]            cmp_a,
  output logic [31:0]            cmp_b,
  output logic                   cmp_valid,
  input  logic                   cmp_q,
  input  logic                   cmp_q_valid,
  output logic [31:0]            out_value,
  output logic [INDEX_WIDTH-1:0] out_index,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_FIRST = 2'd0,  // waiting for the seed element of a vector
    S_NEXT  = 2'd1,  // waiting for the next candidate
    S_WAIT  = 2'd2,  // one compare outstanding, input stalled
    S_DONE  = 2'd3   // result presented, waiting for consumer
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] IDX_ZERO = '0;
  localparam logic [INDEX_WIDTH-1:0] IDX_ONE  = {{(INDEX_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [31:0]            min_q, min_d;
  logic [INDEX_WIDTH-1:0] min_idx_q, min_idx_d;
  logic [31:0]            cand_q, cand_d;
  logic                   cand_last_q, cand_last_d;
  // Index of the candidate now in flight. It is also the number of elements
  // consumed so far. It wraps modulo 2^INDEX_WIDTH.
  logic [INDEX_WIDTH-1:0] count_q, count_d;
  logic [31:0]            cmp_a_q, cmp_a_d;
  logic [31:0]            cmp_b_q, cmp_b_d;
  logic                   cmp_valid_q, cmp_valid_d;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_FIRST;
      min_q       <= '0;
      min_idx_q   <= '0;
      cand_q      <= '0;
      cand_last_q <= 1'b0;
      count_q     <= '0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      cmp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      min_idx_q   <= min_idx_d;
      cand_q      <= cand_d;
      cand_last_q <= cand_last_d;
      count_q     <= count_d;
      cmp_a_q     <= cmp_a_d;
      cmp_b_q     <= cmp_b_d;
      cmp_valid_q <= cmp_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    min_d       = min_q;
    min_idx_d   = min_idx_q;
    cand_d      = cand_q;
    cand_last_d = cand_last_q;
    count_d     = count_q;
    // The compare operands hold their values between requests. Only the
    // request strobe drops back to zero.
    cmp_a_d     = cmp_a_q;
    cmp_b_d     = cmp_b_q;
    cmp_valid_d = 1'b0;

    case (state_q)
      S_FIRST: begin
        // The seed element becomes the minimum outright. No compare is issued,
        // so a NaN seed is never replaced later: the comparator returns 0
        // whenever an operand is NaN.
        if (in_valid) begin
          min_d     = in_value;
          min_idx_d = IDX_ZERO;
          count_d   = IDX_ONE;
          state_d   = in_last ? S_DONE : S_NEXT;
        end
      end

      S_NEXT: begin
        if (in_valid) begin
          cand_d      = in_value;
          cand_last_d = in_last;
          cmp_valid_d = 1'b1;
          cmp_a_d     = in_value;
          cmp_b_d     = min_q;
          state_d     = S_WAIT;
        end
      end

      S_WAIT: begin
        // Results are consumed only in this state. A result that arrives
        // anywhere else is dropped, including one left over from before a
        // reset. The less-than is strict, so on a tie the earlier index stays.
        if (cmp_q_valid) begin
          if (cmp_q) begin
            min_d     = cand_q;
            min_idx_d = count_q;
          end
          count_d = count_q + IDX_ONE;
          state_d = cand_last_q ? S_DONE : S_NEXT;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_FIRST;
        end
      end

      default: begin
        state_d = S_FIRST;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs, all decoded from registers
  // ---------------------------------------------------------------------------
  assign in_ready  = (state_q == S_FIRST) || (state_q == S_NEXT);
  assign out_valid = (state_q == S_DONE);
  // min/min_idx do not change in S_DONE, so the result stays stable until it
  // is transferred.
  assign out_value = min_q;
  assign out_index = min_idx_q;
  assign cmp_a     = cmp_a_q;
  assign cmp_b     = cmp_b_q;
  assign cmp_valid = cmp_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_float_argmin_reduce.sv
module tb_float_argmin_reduce;

  // --------------------------------------------------------------------------
  // Clock / reset block
  // --------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] in_value;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;
  logic        cmp_q;
  logic        cmp_q_valid;

  // Full-width instance
  logic        in_ready;
  logic [31:0] cmp_a, cmp_b;
  logic        cmp_valid;
  logic [31:0] out_value;
  logic [15:0] out_index;
  logic        out_valid;
  logic [1:0]  dbg_state;

  // Narrow-index instance: it gets the same stimulus and shows index wrap
  logic        n_in_ready;
  logic [31:0] n_cmp_a, n_cmp_b;
  logic        n_cmp_valid;
  logic [31:0] n_out_value;
  logic [1:0]  n_out_index;
  logic        n_out_valid;
  logic [1:0]  n_dbg_state;

  float_argmin_reduce #(.INDEX_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_value(in_value), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_valid(cmp_valid), .cmp_q(cmp_q), .cmp_q_valid(cmp_q_valid),
    .out_value(out_value), .out_index(out_index), .out_valid(out_valid),
    .out_ready(out_ready), .dbg_state(dbg_state)
  );

  float_argmin_reduce #(.INDEX_WIDTH(2)) dut_n (
    .clk(clk), .reset(reset), .in_value(in_value), .in_valid(in_valid),
    .in_last(in_last), .in_ready(n_in_ready), .cmp_a(n_cmp_a), .cmp_b(n_cmp_b),
    .cmp_valid(n_cmp_valid), .cmp_q(cmp_q), .cmp_q_valid(cmp_q_valid),
    .out_value(n_out_value), .out_index(n_out_index), .out_valid(n_out_valid),
    .out_ready(out_ready), .dbg_state(n_dbg_state)
  );

  // --------------------------------------------------------------------------
  // Comparator model with configurable latency
  // --------------------------------------------------------------------------
  int   lat = 0;
  int   pend_cnt = 0;
  logic pipe_valid = 1'b0;
  logic pipe_res = 1'b0;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic flt_lt(input logic [31:0] a, input logic [31:0] b);
    if (is_nan(a) || is_nan(b)) return 1'b0;
    if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) return 1'b0;
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction

  always @(negedge clk) begin
    pipe_valid = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt = pend_cnt - 1;
      if (pend_cnt == 0) pipe_valid = 1'b1;
    end
    if (cmp_valid && lat > 0) begin
      pend_cnt = lat;
      pipe_res = flt_lt(cmp_a, cmp_b);
    end
  end

  assign cmp_q_valid = (lat == 0) ? cmp_valid : pipe_valid;
  assign cmp_q       = (lat == 0) ? flt_lt(cmp_a, cmp_b) : pipe_res;

  int cmp_cnt = 0;
  always @(negedge clk) if (cmp_valid) cmp_cnt++;

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Vector table
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [3:0]       n;
    logic [3:0]       lat;
    logic [4:0][31:0] v;
    logic [31:0]      exp_val;
    logic [15:0]      exp_idx;
    logic [1:0]       exp_idx_n;
    logic [3:0]       exp_cmps;
  } vec_t;

  localparam int NVEC = 8;
  vec_t tbl[NVEC];

  task automatic set_vec(input int k, input int n, input int l,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] d, input logic [31:0] e,
                         input logic [31:0] ev, input int ei, input int ein, input int ec);
    tbl[k].n = 4'(n);
    tbl[k].lat = 4'(l);
    tbl[k].v[0] = a; tbl[k].v[1] = b; tbl[k].v[2] = c;
    tbl[k].v[3] = d; tbl[k].v[4] = e;
    tbl[k].exp_val = ev;
    tbl[k].exp_idx = 16'(ei);
    tbl[k].exp_idx_n = 2'(ein);
    tbl[k].exp_cmps = 4'(ec);
  endtask

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  // Called just after a rising edge. Each element is presented at a negedge.
  // The gaps in in_ready between accepts are checked against the comparator
  // latency.
  task automatic send_vec(input vec_t t, input string name);
    int waits;
    @(negedge clk);
    for (int i = 0; i < int'(t.n); i++) begin
      in_value = t.v[i];
      in_valid = 1'b1;
      in_last  = (i == int'(t.n) - 1);
      waits = 0;
      while (!in_ready && waits < 100) begin
        @(negedge clk);
        waits++;
      end
      chk({name, " ready_gap"}, 32'(waits), (i <= 1) ? 32'd0 : 32'(int'(t.lat) + 1));
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called at the negedge right after the last accept.
  task automatic get_result(input string name, input logic [31:0] ev, input logic [15:0] ei,
                            input logic [1:0] ein, input int exp_wait);
    int w;
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk({name, " out_latency"}, 32'(w), 32'(exp_wait));
    exp_q.push_back(ev);
    chk({name, " out_value"}, out_value, exp_q.pop_front());
    chk({name, " out_index"}, 32'(out_index), 32'(ei));
    chk({name, " n_out_index"}, 32'(n_out_index), 32'(ein));
    chk({name, " n_out_value"}, n_out_value, ev);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, " ready_after"}, 32'(in_ready), 32'd1);
    chk({name, " valid_after"}, 32'(out_valid), 32'd0);
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    vec_t hv;
    reset = 1'b0; in_value = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;

    set_vec(0, 4, 3, 32'h40400000, 32'h3F800000, 32'h40000000, 32'h3F800000, 0,
            32'h3F800000, 1, 1, 3);
    set_vec(1, 1, 1, 32'hC0B00000, 0, 0, 0, 0, 32'hC0B00000, 0, 0, 0);
    set_vec(2, 3, 0, 32'h40000000, 32'h7FC00000, 32'hBF000000, 0, 0,
            32'hBF000000, 2, 2, 2);
    set_vec(3, 5, 2, 32'h40A00000, 32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000,
            32'h3F800000, 4, 0, 4);
    set_vec(4, 3, 1, 32'h7FC00000, 32'h3F800000, 32'hC0400000, 0, 0,
            32'h7FC00000, 0, 0, 2);
    set_vec(5, 2, 0, 32'h80000000, 32'h00000000, 0, 0, 0, 32'h80000000, 0, 0, 1);
    set_vec(6, 3, 2, 32'h3F800000, 32'hFF800000, 32'hBF800000, 0, 0,
            32'hFF800000, 1, 1, 2);
    set_vec(7, 2, 0, 32'hBF800000, 32'hC0000000, 0, 0, 0, 32'hC0000000, 1, 1, 1);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst cmp_valid", 32'(cmp_valid), 32'd0);
    chk("rst cmp_a", cmp_a, 32'd0);
    chk("rst cmp_b", cmp_b, 32'd0);
    chk("rst out_value", out_value, 32'd0);
    chk("rst out_index", 32'(out_index), 32'd0);
    chk("rst state", 32'(dbg_state), 32'd0);
    reset = 1'b1;

    // Table-driven vectors
    for (int k = 0; k < NVEC; k++) begin
      @(posedge clk);
      lat = int'(tbl[k].lat);
      cmp_cnt = 0;
      send_vec(tbl[k], $sformatf("vec%0d", k));
      get_result($sformatf("vec%0d", k), tbl[k].exp_val, tbl[k].exp_idx, tbl[k].exp_idx_n,
                 (tbl[k].n == 4'd1) ? 0 : int'(tbl[k].lat) + 1);
      chk($sformatf("vec%0d cmp_pulses", k), 32'(cmp_cnt), 32'(tbl[k].exp_cmps));
    end

    // Result held while out_ready is low
    hv = '0;
    hv.n = 4'd2; hv.lat = 4'd1; hv.v[0] = 32'h40800000; hv.v[1] = 32'h40E00000;
    @(posedge clk);
    lat = 1;
    send_vec(hv, "hold");
    for (int w = 0; w < 100 && !out_valid; w++) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk("hold out_valid", 32'(out_valid), 32'd1);
      chk("hold out_value", out_value, 32'h40800000);
      chk("hold out_index", 32'(out_index), 32'd0);
      chk("hold in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold ready_next", 32'(in_ready), 32'd1);
    chk("hold valid_next", 32'(out_valid), 32'd0);

    // Reset during S_WAIT, then a stale comparator result arrives
    lat = 3;
    in_value = 32'h40A00000; in_valid = 1'b1; in_last = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_value = 32'h3F800000;
    @(posedge clk);
    @(negedge clk);
    chk("abort in_wait", 32'(dbg_state), 32'd2);
    in_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort cmp_a", cmp_a, 32'd0);
    chk("abort cmp_b", cmp_b, 32'd0);
    chk("abort out_value", out_value, 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("abort out_valid", 32'(out_valid), 32'd0);
      chk("abort state", 32'(dbg_state), 32'd0);
    end
    hv = '0;
    hv.n = 4'd2; hv.lat = 4'd3; hv.v[0] = 32'h40E00000; hv.v[1] = 32'h40800000;
    @(posedge clk);
    cmp_cnt = 0;
    send_vec(hv, "post_abort");
    get_result("post_abort", 32'h40800000, 16'd1, 2'd1, 4);
    chk("post_abort cmp_pulses", 32'(cmp_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
